debayer_line_scheduler: RTL and testbench
=========================================

// Module: debayer_line_scheduler
// PURPOSE
//  Sequences the 4-line RAM ring that feeds the debayer datapath. Tracks frame/line
//  boundaries from the CSI depacker strobes and drives the datapath controls: RAM write
//  select, shared line address, three read indices (prev/centre/next) and line parity.
//  Suppresses output during the priming line and reports per-frame line counts and errors.
//  Sits between the raw depacker and the debayer filter.
// PARAMETERS
//  LINE_WORDS   1024  max RAM words per line (pixel groups per line); address width = clog2
//  LINE_CNT_W   12    width of the per-frame line counter
// PORTS
//  clk_i             in   1   pixel-group clock
//  reset_i           in   1   synchronous, active-low reset
//  frame_valid_i     in   1   high for the whole frame
//  line_valid_i      in   1   high for the whole line
//  data_valid_i      in   1   one pixel group on data bus this cycle
//  bayer_pattern_i   in   2   [1]=first row odd, [0]=first col odd; sampled at frame start
//  write_ram_select_o out 4   one-hot RAM write enable for the current line
//  line_address_o    out  clog2(LINE_WORDS)  shared RAM read/write address
//  rd_idx_prev_o     out  2   RAM holding line n-2
//  rd_idx_centre_o   out  2   RAM holding line n-1 (line being debayered)
//  rd_idx_next_o     out  2   RAM being written (line n)
//  line_odd_o        out  1   parity of the centre line, selects odd/even kernel
//  col_odd_o         out  1   latched bayer_pattern_i[0] for this frame
//  out_enable_o      out  1   datapath output qualifier (gates output_valid)
//  frame_done_o      out  1   one-cycle pulse on frame end
//  line_count_o      out  LINE_CNT_W  lines completed in last frame, valid with frame_done_o
//  overflow_o        out  1   sticky: line exceeded LINE_WORDS
//  protocol_err_o    out  1   sticky: line_valid_i high while not in a frame
// BEHAVIOUR
//  Reset (reset_i=0 at posedge): state=IDLE, write_ram_select_o=4'b0001, line_address_o=0,
//   rd_idx_next=0, rd_idx_centre=3, rd_idx_prev=2, line_odd_o=0, col_odd_o=0,
//   out_enable_o=0, frame_done_o=0, line_count_o=0, overflow_o=0, protocol_err_o=0.
//   Reset mid-frame aborts it; no frame_done_o; waits for next frame_valid_i rise.
//  Edges detected against a registered copy of frame_valid_i/line_valid_i.
//  FSM: IDLE -frame_valid rise-> PRIME -first line fall-> STREAM -frame_valid fall-> IDLE.
//   IDLE->PRIME: reload ring to reset values, line counter=0, line_odd_o<=bayer_pattern_i[1],
//    col_odd_o<=bayer_pattern_i[0].
//   PRIME: first line written, out_enable_o=0.
//   STREAM: out_enable_o = line_valid_i (registered, 1-cycle latency from line_valid_i).
//  Line end (line_valid fall, state PRIME/STREAM): rotate write select left by 1 (wrap 3->0),
//   all three indices +1 mod 4, toggle line_odd_o, line counter +1 (saturating).
//   Updated values visible from the cycle after the fall, stable before the next line.
//  Address: 0 while line_valid_i=0; +1 on each cycle with line_valid_i&data_valid_i.
//   At LINE_WORDS-1 with a further beat: hold address, set overflow_o.
//  Frame end (frame_valid fall): frame_done_o=1 one cycle, line_count_o=counter,
//   out_enable_o=0, ->IDLE. If line_valid falls in the same cycle, the rotation and
//   count are applied first and included in line_count_o.
//  line_valid_i rise in IDLE: ignored, protocol_err_o set.
//  frame_valid_i rise while already in frame (glitch): treated as new frame start.
//  Sticky flags clear only on reset.
// STRUCTURE
//  Shared package: state enum (IDLE/PRIME/STREAM), RAM count constant 4, reset ring
//   index constants.
//  One sub-module: debayer_ring_ptr (one-hot select + three 2-bit indices, rotate/reload).
// TESTING
//  Reset, frame of 4 lines x 8 beats -> select 0001,0010,0100,1000; line_count_o=4 at frame_done_o.
//  Line 3 of a frame -> rd_idx next/centre/prev = 2/1/0; line_odd_o toggles each line.
//  Line of 1025 beats with LINE_WORDS=1024 -> address holds 1023, overflow_o=1 stays set.
//  line_valid pulse with frame_valid=0 -> protocol_err_o=1, select unchanged at 0001.
//  reset_i=0 during line 2 -> all outputs reset values, no frame_done_o; next frame starts at RAM0.
//  bayer_pattern_i=2'b11 at frame start -> line_odd_o=1 and col_odd_o=1 on first line; PRIME
//   line gives out_enable_o=0, second line out_enable_o=1.

Source files
------------

// File: rtl/debayer_line_scheduler_pkg.sv
// Shared types and ring constants for the debayer line scheduler and its RAM ring pointer.
// Combinational helpers only; no latency, no backpressure.
package debayer_line_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  localparam int RAM_CNT = 4;

  // Ring state at frame start: write RAM0, centre = RAM3, prev = RAM2.
  localparam logic [RAM_CNT-1:0] RST_WR_SEL     = 4'b0001;
  localparam logic [1:0]         RST_IDX_NEXT   = 2'd0;
  localparam logic [1:0]         RST_IDX_CENTRE = 2'd3;
  localparam logic [1:0]         RST_IDX_PREV   = 2'd2;

  function automatic logic [RAM_CNT-1:0] rotl_sel(input logic [RAM_CNT-1:0] sel);
    return {sel[RAM_CNT-2:0], sel[RAM_CNT-1]};
  endfunction

endpackage

// File: rtl/debayer_line_scheduler_if.sv
// Depacker strobes in, line-RAM/datapath controls out; master = strobe source, slave = scheduler.
// Pure wiring; no latency, no backpressure (strobes are unconditional).
interface debayer_line_scheduler_if #(
  parameter int LINE_WORDS = 1024,
  parameter int LINE_CNT_W = 12
);
  localparam int ADDR_W = $clog2(LINE_WORDS);

  logic                  frame_valid_i;
  logic                  line_valid_i;
  logic                  data_valid_i;
  logic [1:0]            bayer_pattern_i;
  logic [3:0]            write_ram_select_o;
  logic [ADDR_W-1:0]     line_address_o;
  logic [1:0]            rd_idx_prev_o;
  logic [1:0]            rd_idx_centre_o;
  logic [1:0]            rd_idx_next_o;
  logic                  line_odd_o;
  logic                  col_odd_o;
  logic                  out_enable_o;
  logic                  frame_done_o;
  logic [LINE_CNT_W-1:0] line_count_o;
  logic                  overflow_o;
  logic                  protocol_err_o;

  modport master (
    output frame_valid_i, line_valid_i, data_valid_i, bayer_pattern_i,
    input  write_ram_select_o, line_address_o, rd_idx_prev_o, rd_idx_centre_o,
           rd_idx_next_o, line_odd_o, col_odd_o, out_enable_o, frame_done_o,
           line_count_o, overflow_o, protocol_err_o
  );

  modport slave (
    input  frame_valid_i, line_valid_i, data_valid_i, bayer_pattern_i,
    output write_ram_select_o, line_address_o, rd_idx_prev_o, rd_idx_centre_o,
           rd_idx_next_o, line_odd_o, col_odd_o, out_enable_o, frame_done_o,
           line_count_o, overflow_o, protocol_err_o
  );

endinterface

// File: rtl/debayer_ring_ptr.sv
// 4-RAM ring pointer: one-hot write select plus next/centre/prev read indices.
// Updates one cycle after reload_i/rotate_i; no backpressure.
module debayer_ring_ptr
  import debayer_line_scheduler_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               reload_i,
  input  logic               rotate_i,
  output logic [RAM_CNT-1:0] wr_sel_o,
  output logic [1:0]         idx_next_o,
  output logic [1:0]         idx_centre_o,
  output logic [1:0]         idx_prev_o
);

  logic [RAM_CNT-1:0] sel_q;
  logic [1:0]         next_q;
  logic [1:0]         centre_q;
  logic [1:0]         prev_q;

  // Reload wins over rotate so a frame restart always lands on RAM0.
  always_ff @(posedge clk_i) begin
    if (!reset_i || reload_i) begin
      sel_q    <= RST_WR_SEL;
      next_q   <= RST_IDX_NEXT;
      centre_q <= RST_IDX_CENTRE;
      prev_q   <= RST_IDX_PREV;
    end else if (rotate_i) begin
      sel_q    <= rotl_sel(sel_q);
      next_q   <= next_q + 2'd1;
      centre_q <= centre_q + 2'd1;
      prev_q   <= prev_q + 2'd1;
    end
  end

  assign wr_sel_o     = sel_q;
  assign idx_next_o   = next_q;
  assign idx_centre_o = centre_q;
  assign idx_prev_o   = prev_q;

endmodule

// File: rtl/debayer_line_scheduler.sv
// Frame/line sequencer for the debayer line-RAM ring; all outputs registered, 1 cycle after the strobes.
// No backpressure: strobes are consumed every cycle, excess beats only raise overflow_o.
module debayer_line_scheduler
  import debayer_line_scheduler_pkg::*;
#(
  parameter int LINE_WORDS = 1024,
  parameter int LINE_CNT_W = 12
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  debayer_line_scheduler_if.slave bus
);

  localparam int                    ADDR_W   = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0]     ADDR_MAX = ADDR_W'(LINE_WORDS - 1);
  localparam logic [LINE_CNT_W-1:0] CNT_MAX  = '1;

  logic fv_q, lv_q;
  logic fv_rise, fv_fall, lv_rise, lv_fall;

  // Edge history keeps sampling through reset, so a frame still open at reset
  // release is not mistaken for a new start.
  always_ff @(posedge clk_i) begin
    fv_q <= bus.frame_valid_i;
    lv_q <= bus.line_valid_i;
  end

  assign fv_rise = bus.frame_valid_i & ~fv_q;
  assign fv_fall = ~bus.frame_valid_i & fv_q;
  assign lv_rise = bus.line_valid_i & ~lv_q;
  assign lv_fall = ~bus.line_valid_i & lv_q;

  state_e                state_q;
  logic [LINE_CNT_W-1:0] cnt_q, cnt_d;
  logic [LINE_CNT_W-1:0] line_count_q;
  logic                  line_odd_q, col_odd_q, out_en_q, frame_done_q, perr_q;
  logic                  line_end;

  assign line_end = lv_fall && (state_q != ST_IDLE);
  assign cnt_d    = (line_end && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      line_count_q <= '0;
      line_odd_q   <= 1'b0;
      col_odd_q    <= 1'b0;
      out_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (fv_rise) begin
        state_q    <= ST_PRIME;
        cnt_q      <= '0;
        line_odd_q <= bus.bayer_pattern_i[1];
        col_odd_q  <= bus.bayer_pattern_i[0];
        out_en_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            out_en_q <= 1'b0;
            if (lv_rise) perr_q <= 1'b1;
          end
          ST_PRIME, ST_STREAM: begin
            out_en_q <= (state_q == ST_STREAM) && bus.line_valid_i;
            cnt_q    <= cnt_d;
            if (line_end) begin
              line_odd_q <= ~line_odd_q;
              state_q    <= ST_STREAM;
            end
            // Any line closing on this same edge is already folded into cnt_d.
            if (fv_fall) begin
              frame_done_q <= 1'b1;
              line_count_q <= cnt_d;
              out_en_q     <= 1'b0;
              state_q      <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;

  // full marks that word LINE_WORDS-1 has been written; only a beat after that overflows.
  always_comb begin
    addr_d = addr_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    if (!bus.line_valid_i) begin
      addr_d = '0;
      full_d = 1'b0;
    end else if (bus.data_valid_i) begin
      if (full_q) begin
        ovf_d = 1'b1;
      end else if (addr_q == ADDR_MAX) begin
        full_d = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      addr_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  logic [RAM_CNT-1:0] wr_sel;
  logic [1:0]         idx_next, idx_centre, idx_prev;

  debayer_ring_ptr u_ring (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .reload_i     (fv_rise),
    .rotate_i     (line_end && !fv_rise),
    .wr_sel_o     (wr_sel),
    .idx_next_o   (idx_next),
    .idx_centre_o (idx_centre),
    .idx_prev_o   (idx_prev)
  );

  assign bus.write_ram_select_o = wr_sel;
  assign bus.rd_idx_next_o      = idx_next;
  assign bus.rd_idx_centre_o    = idx_centre;
  assign bus.rd_idx_prev_o      = idx_prev;
  assign bus.line_address_o     = addr_q;
  assign bus.line_odd_o         = line_odd_q;
  assign bus.col_odd_o          = col_odd_q;
  assign bus.out_enable_o       = out_en_q;
  assign bus.frame_done_o       = frame_done_q;
  assign bus.line_count_o       = line_count_q;
  assign bus.overflow_o         = ovf_q;
  assign bus.protocol_err_o     = perr_q;

endmodule

// File: tb/tb_debayer_line_scheduler.sv
// Directed bench for debayer_line_scheduler: inputs change on negedge, outputs sampled on negedge.
module tb_debayer_line_scheduler;

  localparam int LW = 1024;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst_n;

  initial forever #5 clk = ~clk;

  debayer_line_scheduler_if #(.LINE_WORDS(LW), .LINE_CNT_W(CW)) bus();

  debayer_line_scheduler #(.LINE_WORDS(LW), .LINE_CNT_W(CW)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic fv, input logic lv, input logic dv);
    @(negedge clk);
    bus.frame_valid_i = fv;
    bus.line_valid_i  = lv;
    bus.data_valid_i  = dv;
  endtask

  // Snapshot taken after the third beat of a line, and at the line's falling edge.
  logic [3:0]  s_sel;
  logic [1:0]  s_nx, s_ce, s_pv;
  logic        s_odd, s_col, s_oe, s_ovf;
  logic [31:0] s_addr, e_addr;
  logic        e_ovf;

  task automatic run_line(input int beats, input bit last);
    for (int i = 1; i <= beats; i++) begin
      cyc(1'b1, 1'b1, 1'b1);
      if (i == 3) begin
        s_sel  = bus.write_ram_select_o;
        s_nx   = bus.rd_idx_next_o;
        s_ce   = bus.rd_idx_centre_o;
        s_pv   = bus.rd_idx_prev_o;
        s_odd  = bus.line_odd_o;
        s_col  = bus.col_odd_o;
        s_oe   = bus.out_enable_o;
        s_ovf  = bus.overflow_o;
        s_addr = 32'(bus.line_address_o);
      end
    end
    cyc(last ? 1'b0 : 1'b1, 1'b0, 1'b0);
    e_addr = 32'(bus.line_address_o);
    e_ovf  = bus.overflow_o;
    if (!last) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic chk_line(input string tag, input logic [3:0] sel, input logic [1:0] nx,
                          input logic [1:0] ce, input logic [1:0] pv, input logic odd,
                          input logic oe);
    chk({tag, "_sel"}, 32'(s_sel), 32'(sel));
    chk({tag, "_next"}, 32'(s_nx), 32'(nx));
    chk({tag, "_centre"}, 32'(s_ce), 32'(ce));
    chk({tag, "_prev"}, 32'(s_pv), 32'(pv));
    chk({tag, "_odd"}, 32'(s_odd), 32'(odd));
    chk({tag, "_oe"}, 32'(s_oe), 32'(oe));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, 32'(bus.write_ram_select_o), 32'h1);
    chk({tag, "_addr"}, 32'(bus.line_address_o), 32'h0);
    chk({tag, "_next"}, 32'(bus.rd_idx_next_o), 32'h0);
    chk({tag, "_centre"}, 32'(bus.rd_idx_centre_o), 32'h3);
    chk({tag, "_prev"}, 32'(bus.rd_idx_prev_o), 32'h2);
    chk({tag, "_odd"}, 32'(bus.line_odd_o), 32'h0);
    chk({tag, "_col"}, 32'(bus.col_odd_o), 32'h0);
    chk({tag, "_oe"}, 32'(bus.out_enable_o), 32'h0);
    chk({tag, "_done"}, 32'(bus.frame_done_o), 32'h0);
    chk({tag, "_lcnt"}, 32'(bus.line_count_o), 32'h0);
    chk({tag, "_ovf"}, 32'(bus.overflow_o), 32'h0);
    chk({tag, "_perr"}, 32'(bus.protocol_err_o), 32'h0);
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.frame_valid_i   = 1'b0;
    bus.line_valid_i    = 1'b0;
    bus.data_valid_i    = 1'b0;
    bus.bayer_pattern_i = 2'b00;
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk_reset("rst");
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // Line pulse outside a frame.
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("perr_set", 32'(bus.protocol_err_o), 32'h1);
    chk("perr_sel", 32'(bus.write_ram_select_o), 32'h1);
    chk("perr_next", 32'(bus.rd_idx_next_o), 32'h0);

    // Frame A: 4 lines x 8 beats, pattern 00.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    run_line(8, 1'b0);
    chk_line("a1", 4'b0001, 2'd0, 2'd3, 2'd2, 1'b0, 1'b0);
    chk("a1_addr_mid", s_addr, 32'd2);
    chk("a1_addr_end", e_addr, 32'd8);
    run_line(8, 1'b0);
    chk_line("a2", 4'b0010, 2'd1, 2'd0, 2'd3, 1'b1, 1'b1);
    run_line(8, 1'b0);
    chk_line("a3", 4'b0100, 2'd2, 2'd1, 2'd0, 1'b0, 1'b1);
    run_line(8, 1'b0);
    chk_line("a4", 4'b1000, 2'd3, 2'd2, 2'd1, 1'b1, 1'b1);
    chk("a_addr_gap", 32'(bus.line_address_o), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("a_done", 32'(bus.frame_done_o), 32'h1);
    chk("a_lcnt", 32'(bus.line_count_o), 32'd4);
    cyc(1'b0, 1'b0, 1'b0);
    chk("a_done_pulse", 32'(bus.frame_done_o), 32'h0);
    chk("a_lcnt_hold", 32'(bus.line_count_o), 32'd4);
    chk("a_oe_idle", 32'(bus.out_enable_o), 32'h0);

    // Frame B: pattern 11, last line ends on the same edge as the frame.
    bus.bayer_pattern_i = 2'b11;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    bus.bayer_pattern_i = 2'b00;
    run_line(8, 1'b0);
    chk_line("b1", 4'b0001, 2'd0, 2'd3, 2'd2, 1'b1, 1'b0);
    chk("b1_col", 32'(s_col), 32'h1);
    run_line(8, 1'b1);
    chk_line("b2", 4'b0010, 2'd1, 2'd0, 2'd3, 1'b0, 1'b1);
    chk("b2_col", 32'(s_col), 32'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("b_done", 32'(bus.frame_done_o), 32'h1);
    chk("b_lcnt", 32'(bus.line_count_o), 32'd2);
    chk("b_sel_after", 32'(bus.write_ram_select_o), 32'h4);
    chk("b_oe_end", 32'(bus.out_enable_o), 32'h0);

    // Frame C: overlong first line, then reset in the middle of line 2.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    run_line(LW + 1, 1'b0);
    chk("c1_sel_reload", 32'(s_sel), 32'h1);
    chk("c1_col", 32'(s_col), 32'h0);
    chk("c1_ovf_mid", 32'(s_ovf), 32'h0);
    chk("c1_addr_hold", e_addr, 32'd1023);
    chk("c1_ovf", 32'(e_ovf), 32'h1);
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    chk("c2_sel", 32'(bus.write_ram_select_o), 32'h2);
    chk("c2_ovf_sticky", 32'(bus.overflow_o), 32'h1);
    chk("c2_addr", 32'(bus.line_address_o), 32'd2);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_reset("midrst");
    cyc(1'b0, 1'b0, 1'b0);
    chk("midrst_no_done", 32'(bus.frame_done_o), 32'h0);

    // Frame D: restart after abort.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    run_line(8, 1'b0);
    chk_line("d1", 4'b0001, 2'd0, 2'd3, 2'd2, 1'b0, 1'b0);
    run_line(5, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("d_done", 32'(bus.frame_done_o), 32'h1);
    chk("d_lcnt", 32'(bus.line_count_o), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
